jb_prach_tdm_serializer: RTL

JB_PRACH_TDM_SERIALIZER -- requirements
Module: jb_prach_tdm_serializer

---
 rtl/jb_prach_pkg.sv | 9 +
 rtl/jb_prach_prio_enc.sv | 27 ++
 rtl/jb_prach_tdm_serializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/jb_prach_pkg.sv
// Shared types and limits for the PRACH TDM serializer.
package jb_prach_pkg;
  localparam int MAX_ANTENNAS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/jb_prach_prio_enc.sv
// Priority encoder: index of the lowest (or highest) set bit plus a non-empty flag.
module jb_prach_prio_enc #(
  parameter int W       = 4,
  parameter int IDX_W   = 2,
  parameter bit HIGHEST = 1'b0
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             nonempty
);

  always_comb begin
    idx      = '0;
    nonempty = |vec;
    // Scan towards the wanted end so the last hit is the winner.
    if (HIGHEST) begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/jb_prach_tdm_serializer.sv
// Serializes a captured vector of per-antenna samples onto one AXI-stream-like port.
// Optional statistics counters are enabled with JB_PRACH_TDM_SERIALIZER_STATS_EN.
module jb_prach_tdm_serializer
  import jb_prach_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = 2
) (
  input  logic                              clk_4x,
  input  logic                              rst_4x,
  input  logic                              clk_en,
  input  logic [N_ANTENNAS-1:0]             ant_enable,
  input  logic [N_ANTENNAS-1:0]             tvalid_in,
  input  logic [N_ANTENNAS*2*PRECISION-1:0] tdata_in,
  input  logic                              tready_in,
  output logic                              tvalid_out,
  output logic [2*PRECISION-1:0]            tdata_out,
  output logic [USR_ID_BW-1:0]              tuser_out,
  output logic                              tlast_out,
  output logic                              busy,
  output logic                              overflow,
  input  logic                              clear_overflow
`ifdef JB_PRACH_TDM_SERIALIZER_STATS_EN
  ,
  output logic [31:0]                       sample_cnt,
  output logic [15:0]                       drop_cnt
`endif
);

  localparam int SW    = 2 * PRECISION;
  localparam int IDX_W = (N_ANTENNAS > 1) ? $clog2(N_ANTENNAS) : 1;

  generate
    if (USR_ID_BW < $clog2(N_ANTENNAS)) begin : g_bad_usr_id_bw
      $error("USR_ID_BW too narrow for N_ANTENNAS");
    end
    if (N_ANTENNAS < 1 || N_ANTENNAS > MAX_ANTENNAS) begin : g_bad_n_antennas
      $error("N_ANTENNAS out of range");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [N_ANTENNAS-1:0] pend_mask_reg, pend_after, pend_next;
  logic [SW-1:0]         bank_reg [N_ANTENNAS];
  logic [SW-1:0]         din      [N_ANTENNAS];
  logic                  xfer, capture_req, capture_ok, drop;
  logic                  overflow_next;
  logic [IDX_W-1:0]      low_idx, high_idx;
  logic                  low_ne, high_ne;
  logic                  tvalid_next, tlast_next;
  logic [SW-1:0]         tdata_next;
  logic [USR_ID_BW-1:0]  tuser_next;

  generate
    for (genvar gi = 0; gi < N_ANTENNAS; gi++) begin : g_bank
      assign din[gi] = tdata_in[gi*SW +: SW];
      always_ff @(posedge clk_4x) begin
        if (capture_ok) bank_reg[gi] <= din[gi];
      end
    end
  endgenerate

  // The presented index is tuser_out, so a transfer retires exactly that bit.
  always_comb begin
    xfer        = tvalid_out & tready_in;
    pend_after  = xfer ? (pend_mask_reg & ~(N_ANTENNAS'(1) << tuser_out)) : pend_mask_reg;
    capture_req = clk_en & (|(tvalid_in & ant_enable));
    capture_ok  = 1'b0;
    drop        = 1'b0;
    state_next  = state_reg;
    case (state_reg)
      IDLE: begin
        capture_ok = capture_req;
        if (capture_req) state_next = SHIFT;
      end
      SHIFT: begin
        capture_ok = capture_req & ~(|pend_after);
        drop       = capture_req & (|pend_after);
        if (~(|pend_after) & ~capture_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    pend_next     = capture_ok ? (tvalid_in & ant_enable) : pend_after;
    overflow_next = drop | (overflow & ~clear_overflow);
  end

  jb_prach_prio_enc #(.W(N_ANTENNAS), .IDX_W(IDX_W), .HIGHEST(1'b0)) u_low_enc (
    .vec      (pend_next),
    .idx      (low_idx),
    .nonempty (low_ne)
  );

  jb_prach_prio_enc #(.W(N_ANTENNAS), .IDX_W(IDX_W), .HIGHEST(1'b1)) u_high_enc (
    .vec      (pend_next),
    .idx      (high_idx),
    .nonempty (high_ne)
  );

  // A freshly accepted vector is not in the bank yet, so read it straight from the input.
  always_comb begin
    tvalid_next = low_ne;
    tuser_next  = low_ne ? USR_ID_BW'(low_idx) : '0;
    tdata_next  = '0;
    if (low_ne) tdata_next = capture_ok ? din[low_idx] : bank_reg[low_idx];
    tlast_next  = low_ne & high_ne & (low_idx == high_idx);
  end

  always_ff @(posedge clk_4x) begin
    if (rst_4x) begin
      state_reg     <= IDLE;
      pend_mask_reg <= '0;
      tvalid_out    <= 1'b0;
      tdata_out     <= '0;
      tuser_out     <= '0;
      tlast_out     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_mask_reg <= pend_next;
      tvalid_out    <= tvalid_next;
      tdata_out     <= tdata_next;
      tuser_out     <= tuser_next;
      tlast_out     <= tlast_next;
      overflow      <= overflow_next;
    end
  end

  assign busy = (state_reg == SHIFT);

`ifdef JB_PRACH_TDM_SERIALIZER_STATS_EN
  logic [31:0] sample_cnt_reg;
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk_4x) begin
    if (rst_4x) begin
      sample_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      if (xfer) sample_cnt_reg <= sample_cnt_reg + 32'd1;
      if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign sample_cnt = sample_cnt_reg;
  assign drop_cnt   = drop_cnt_reg;
`endif

endmodule
